mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle control FSM that sequences the shared MIPS datapath: one memory, one ALU, and the IR/A/B/ALUOut registers.
- Replaces single-cycle decoding with per-state Moore control, plus a memory ready handshake with timeout.
- Sits beside the datapath; takes the opcode from the IR and zero from the ALU.
- Supports R-type, LW, SW, BEQ, ADDI and J.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles to wait for mem_ready in a memory state before abort (legal range 2..255).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- op  in  6  opcode from IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- irwrite  out  1  IR load
- memwrite  out  1  memory write request
- alusrca  out  1  ALU A select: 0=PC, 1=A reg
- alusrcb  out  2  ALU B select: 00=B, 01=4, 10=signimm, 11=signimm<<2
- aluop  out  2  00=add, 01=sub, 10=funct-decoded
- pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- pcen  out  1  PC load = pcwrite | (branch & zero)
- regdst  out  1  write register: 0=rt, 1=rd
- memtoreg  out  1  write data: 0=ALUOut, 1=memory data
- regwrite  out  1  register file write
- mem_timeout  out  1  one-cycle pulse on an aborted memory access
- state_o  out  4  current state encoding (debug)

Behaviour:
Reset:
- Async reset forces state=IDLE and clears the wait counter.
- All outputs read 0 in IDLE; the next clock goes to FETCH.
Decode style:
- Control outputs are decoded from the state register only.
- Exceptions: irwrite, pcen and the FETCH/MEMRD/MEMWR exits are qualified by mem_ready; pcen also depends on zero.
States and outputs (unlisted signals are 0):
- FETCH: alusrcb=01, irwrite=pcwrite=mem_ready. Hold until mem_ready=1, then DECODE.
- DECODE: alusrcb=11. Next state by op:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - 000010 -> JUMP
  - other -> see Optional Feature
- MEMADR: alusrca=1, alusrcb=10. LW -> MEMRD; SW -> MEMWR.
- MEMRD: iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: memtoreg=1, regwrite=1, then FETCH.
- MEMWR: iord=1, memwrite=1 held throughout the wait. Exit to FETCH on mem_ready.
- EXECUTE: alusrca=1, aluop=10, then ALUWB.
- ALUWB: regdst=1, regwrite=1, then FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1, so pcen=zero. Then FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, then ADDIWB.
- ADDIWB: regwrite=1, then FETCH.
- JUMP: pcsrc=10, pcen=1, then FETCH.
Memory wait timer:
- Counter clears on entry to FETCH, MEMRD or MEMWR.
- Increments each cycle with mem_ready=0 and saturates at TIMEOUT_CYCLES-1.
- Reaching TIMEOUT_CYCLES-1 with mem_ready=0:
  - pulse mem_timeout for 1 cycle
  - suppress irwrite, pcen, regwrite and memwrite that cycle
  - next state FETCH (re-fetch the same PC)
- mem_ready=1 in the timeout cycle: completion wins and no timeout is raised.
Cycle counts with zero wait states: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
Reset mid-instruction:
- Immediate return to IDLE; all outputs drop asynchronously.
- No partial register or memory write is permitted after reset asserts.
op is sampled only in DECODE and MEMADR; IR stability is the datapath's responsibility.

Optional Feature:
Macro: MC_ILLEGAL_TRAP_EN
- Defined: unknown op in DECODE -> TRAP.
  - TRAP is absorbing until reset; all write enables are 0.
  - Added output illegal_op (1 bit) reads 1 in TRAP, 0 otherwise.
- Undefined: unknown op is treated as a NOP (DECODE -> FETCH); the illegal_op port does not exist.

Decomposition:
- Package mc_pkg holds:
  - state localparams (4-bit, IDLE=0)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALUSRCB_*, PCSRC_*, ALUOP_* encodings
- One sub-module, mem_wait_timer: clear/count/expire counter parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset: reset=1 mid-MEMWR with memwrite=1 -> memwrite drops to 0 in the same cycle; after release, state IDLE -> FETCH.
- LW op=100011, mem_ready always 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
- FETCH with mem_ready low for 3 cycles, then high -> irwrite=pcen=1 exactly in the 4th cycle; DECODE follows.
- BEQ op=000100: zero=1 -> pcen=1 with pcsrc=01 in BRANCH; zero=0 -> pcen=0.
- SW with mem_ready stuck 0, TIMEOUT_CYCLES=4 -> memwrite high 3 cycles, then mem_timeout pulse with memwrite=0; next state FETCH.
- op=111111: with MC_ILLEGAL_TRAP_EN, illegal_op=1 and stuck until reset; without it, FETCH follows DECODE with no writes.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes, opcodes
// and datapath mux/ALU select values.
package mc_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_MEMADR   = 4'd3;
    localparam logic [3:0] ST_MEMRD    = 4'd4;
    localparam logic [3:0] ST_MEMWB    = 4'd5;
    localparam logic [3:0] ST_MEMWR    = 4'd6;
    localparam logic [3:0] ST_EXECUTE  = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_ADDIEXEC = 4'd10;
    localparam logic [3:0] ST_ADDIWB   = 4'd11;
    localparam logic [3:0] ST_JUMP     = 4'd12;
    localparam logic [3:0] ST_TRAP     = 4'd13;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_FETCH    = ST_FETCH,
        S_DECODE   = ST_DECODE,
        S_MEMADR   = ST_MEMADR,
        S_MEMRD    = ST_MEMRD,
        S_MEMWB    = ST_MEMWB,
        S_MEMWR    = ST_MEMWR,
        S_EXECUTE  = ST_EXECUTE,
        S_ALUWB    = ST_ALUWB,
        S_BRANCH   = ST_BRANCH,
        S_ADDIEXEC = ST_ADDIEXEC,
        S_ADDIWB   = ST_ADDIWB,
        S_JUMP     = ST_JUMP,
        S_TRAP     = ST_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // States that wait on the memory handshake and are covered by the timeout.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for memory states: clears on request, counts stalled
// cycles and saturates at TIMEOUT_CYCLES-1, where at_limit is raised.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic at_limit
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    // Stall counter with clear priority and saturation at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (count_en && (count != LIMIT)) begin
            count <= count + 8'd1;
        end else begin
            count <= count;
        end
    end

    assign at_limit = (count == LIMIT);

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory ready handshake and access timeout.
// Optional macro MC_ILLEGAL_TRAP_EN: unknown opcodes enter an absorbing TRAP
// state and the illegal_op output is added; otherwise they act as a NOP.
module mc_controller
    import mc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       mem_timeout,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic       illegal_op,
`endif
    output logic [3:0] state_o
);

    state_t state, state_next;
    logic   in_mem, at_limit, expire, timer_clear;
    logic   pcwrite, branch;

    assign in_mem      = is_mem_state(state);
    assign expire      = in_mem && !mem_ready && at_limit;
    // Any state change (including a timeout re-fetch) starts a fresh wait window.
    assign timer_clear = (state_next != state) || expire;

    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .count_en (in_mem && !mem_ready),
        .at_limit (at_limit)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH: begin
                if (expire)         state_next = S_FETCH;
                else if (mem_ready) state_next = S_DECODE;
                else                state_next = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEXEC;
                    OP_J:         state_next = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_next = S_TRAP;
`else
                    default:      state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                case (op)
                    OP_LW:   state_next = S_MEMRD;
                    OP_SW:   state_next = S_MEMWR;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                if (expire)         state_next = S_FETCH;
                else if (mem_ready) state_next = S_MEMWB;
                else                state_next = S_MEMRD;
            end
            S_MEMWR: begin
                if (expire || mem_ready) state_next = S_FETCH;
                else                     state_next = S_MEMWR;
            end
            S_EXECUTE:  state_next = S_ALUWB;
            S_ADDIEXEC: state_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_IDLE;
        endcase
    end

    // Moore control decode; only handshake-qualified strobes look at inputs.
    always_comb begin
        iord        = 1'b0;
        irwrite     = 1'b0;
        memwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = ALUSRCB_B;
        aluop       = ALUOP_ADD;
        pcsrc       = PCSRC_ALU;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        mem_timeout = expire;
        case (state)
            S_FETCH: begin
                alusrcb = ALUSRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE:   alusrcb = ALUSRCB_IMMSH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
            end
            S_MEMRD:    iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = !expire;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
            end
            S_ADDIWB:   regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: begin
                iord = 1'b0;
            end
        endcase
        pcen = pcwrite | (branch & zero);
    end

    assign state_o = state;
`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_op = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus random
// instruction streams against an instruction-sequence reference model.
module tb_mc_controller;
    import mc_pkg::*;

    localparam int T = 4;
`ifdef MC_ILLEGAL_TRAP_EN
    localparam int NOPS = 6;
`else
    localparam int NOPS = 7;
`endif

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op;
    logic       iord, irwrite, memwrite, alusrca, pcen, regdst, memtoreg, regwrite, mem_timeout;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state_o;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif
    logic [14:0] dut_ctrl;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] m_phase;
    logic [3:0] seq[$];
    int         idx, waited;
    logic [5:0] cur_op;
    logic [5:0] ops[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                           6'b001000, 6'b000010, 6'b111111};

    always #5 clk = ~clk;

    mc_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .mem_timeout(mem_timeout),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .state_o(state_o)
    );

    assign dut_ctrl = {iord, irwrite, memwrite, alusrca, alusrcb, aluop, pcsrc,
                       pcen, regdst, memtoreg, regwrite, mem_timeout};

    function automatic bit is_mem(input logic [3:0] p);
        return (p == ST_FETCH) || (p == ST_MEMRD) || (p == ST_MEMWR);
    endfunction

    // Expected control word straight from the per-state output table.
    function automatic logic [14:0] exp_ctrl(input logic [3:0] p, input logic z,
                                             input logic rdy, input int w);
        logic io, irw, mw, asa, pe, rd, m2r, rw, tmo;
        logic [1:0] asb, aop, ps;
        {io, irw, mw, asa, pe, rd, m2r, rw} = 8'd0;
        asb = 2'b00; aop = 2'b00; ps = 2'b00;
        tmo = is_mem(p) && !rdy && (w == T - 1);
        case (p)
            ST_FETCH:    begin asb = 2'b01; irw = rdy; pe = rdy; end
            ST_DECODE:   asb = 2'b11;
            ST_MEMADR:   begin asa = 1'b1; asb = 2'b10; end
            ST_MEMRD:    io = 1'b1;
            ST_MEMWB:    begin m2r = 1'b1; rw = 1'b1; end
            ST_MEMWR:    begin io = 1'b1; mw = !tmo; end
            ST_EXECUTE:  begin asa = 1'b1; aop = 2'b10; end
            ST_ALUWB:    begin rd = 1'b1; rw = 1'b1; end
            ST_BRANCH:   begin asa = 1'b1; aop = 2'b01; ps = 2'b01; pe = z; end
            ST_ADDIEXEC: begin asa = 1'b1; asb = 2'b10; end
            ST_ADDIWB:   rw = 1'b1;
            ST_JUMP:     begin ps = 2'b10; pe = 1'b1; end
            default:     ;
        endcase
        return {io, irw, mw, asa, asb, aop, ps, pe, rd, m2r, rw, tmo};
    endfunction

    task automatic start_instr();
        seq.delete();
        seq.push_back(ST_FETCH);
        seq.push_back(ST_DECODE);
        idx = 0; waited = 0; m_phase = ST_FETCH;
    endtask

    task automatic model_reset();
        seq.delete();
        idx = 0; waited = 0; m_phase = ST_IDLE;
    endtask

    // Advance the model by one clock: walk the instruction's phase list,
    // stretching memory phases and restarting on a timeout.
    task automatic model_clock(input logic [5:0] o, input logic r);
        if (m_phase == ST_IDLE) begin
            start_instr();
        end else if (m_phase == ST_TRAP) begin
            waited = 0;
        end else if (is_mem(m_phase) && !r && waited == T - 1) begin
            start_instr();
        end else if (is_mem(m_phase) && !r) begin
            waited++;
        end else begin
            if (m_phase == ST_DECODE) begin
                case (o)
                    6'b000000: begin seq.push_back(ST_EXECUTE); seq.push_back(ST_ALUWB); end
                    6'b100011, 6'b101011: seq.push_back(ST_MEMADR);
                    6'b000100: seq.push_back(ST_BRANCH);
                    6'b001000: begin seq.push_back(ST_ADDIEXEC); seq.push_back(ST_ADDIWB); end
                    6'b000010: seq.push_back(ST_JUMP);
`ifdef MC_ILLEGAL_TRAP_EN
                    default:   seq.push_back(ST_TRAP);
`else
                    default:   ;
`endif
                endcase
            end else if (m_phase == ST_MEMADR) begin
                if (o == 6'b100011) begin
                    seq.push_back(ST_MEMRD); seq.push_back(ST_MEMWB);
                end else if (o == 6'b101011) begin
                    seq.push_back(ST_MEMWR);
                end
            end
            idx++; waited = 0;
            if (idx >= seq.size()) start_instr();
            else m_phase = seq[idx];
        end
    endtask

    // One cycle: drive inputs, check outputs mid-cycle, clock the model.
    task automatic step(input logic [5:0] o, input logic z, input logic r);
        logic [14:0] e;
        op = o; zero = z; mem_ready = r;
        #4;
        e = exp_ctrl(m_phase, z, r, waited);
        n_vec++;
        assert (dut_ctrl === e) else begin
            n_err++;
            $error("FAIL ctrl phase=%0d got=%b exp=%b", m_phase, dut_ctrl, e);
        end
        n_vec++;
        assert (state_o === m_phase) else begin
            n_err++;
            $error("FAIL state got=%0d exp=%0d", state_o, m_phase);
        end
`ifdef MC_ILLEGAL_TRAP_EN
        n_vec++;
        assert (illegal_op === (m_phase == ST_TRAP)) else begin
            n_err++;
            $error("FAIL illegal_op got=%b exp=%b", illegal_op, (m_phase == ST_TRAP));
        end
`endif
        @(posedge clk);
        model_clock(o, r);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #5;
        n_vec++;
        assert (dut_ctrl === 15'd0 && state_o === 4'd0) else begin
            n_err++;
            $error("FAIL reset_state ctrl=%b state=%0d exp ctrl=0 state=0", dut_ctrl, state_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        step(6'd0, 1'b0, 1'b0);                                   // IDLE

        for (int i = 0; i < 5; i++) step(6'b100011, 1'b0, 1'b1);  // LW, no waits

        for (int i = 0; i < 3; i++) step(6'($urandom), 1'b0, 1'b0); // FETCH stall
        step(6'b000000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(6'b000000, 1'b0, 1'b1);  // R-type rest

        for (int i = 0; i < 3; i++) step(6'b000100, 1'b1, 1'b1);  // BEQ taken
        for (int i = 0; i < 3; i++) step(6'b000100, 1'b0, 1'b1);  // BEQ not taken

        for (int i = 0; i < 3; i++) step(6'b101011, 1'b0, 1'b1);  // SW timeout
        for (int i = 0; i < 4; i++) step(6'b101011, 1'b0, 1'b0);
        step(6'b000010, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(6'b000010, 1'b0, 1'b1);  // J

        for (int i = 0; i < 3; i++) step(6'b101011, 1'b0, 1'b1);  // SW, ready at limit
        for (int i = 0; i < 3; i++) step(6'b101011, 1'b0, 1'b0);
        step(6'b101011, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) step(6'b001000, 1'b0, 1'b1);  // ADDI

        for (int i = 0; i < 2; i++) step(6'b111111, 1'b0, 1'b1);  // illegal op
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) step(6'b000000, 1'b0, 1'b1);
        reset = 1'b1; model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        step(6'd0, 1'b0, 1'b0);
`else
        step(6'b000010, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(6'b000010, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 300; i++) begin
            int thr;
            logic [5:0] o;
            if (m_phase == ST_FETCH) cur_op = ops[$urandom_range(0, NOPS - 1)];
            thr = (((i / 40) % 2) == 0) ? 85 : 25;
            o = ((m_phase == ST_DECODE) || (m_phase == ST_MEMADR)) ? cur_op : 6'($urandom);
            step(o, 1'($urandom), ($urandom_range(0, 99) < thr));
        end

        // Drive to a clean FETCH, then reset in the middle of a store wait.
        for (int i = 0; i < 10 && m_phase != ST_FETCH; i++) step(6'b000000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(6'b101011, 1'b0, 1'b1);
        op = 6'b101011; zero = 1'b0; mem_ready = 1'b0;
        #2;
        n_vec++;
        assert (memwrite === 1'b1) else begin
            n_err++;
            $error("FAIL memwr_before_reset got=%b exp=1", memwrite);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        assert (dut_ctrl === 15'd0 && state_o === 4'd0) else begin
            n_err++;
            $error("FAIL async_reset ctrl=%b state=%0d exp ctrl=0 state=0", dut_ctrl, state_o);
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        step(6'd0, 1'b0, 1'b1);
        step(6'd0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
